// File: rtl/eth_tx_avst_rr_arb.sv
// eth_tx_avst_rr_arb
//   Packet-atomic round-robin arbiter sharing the CMAC TX AVST port among
//   NUM_REQ AVST packet sources. A grant is locked from SOP to EOP. The beat to
//   the CMAC goes through a single registered output stage. Beats that arrive
//   without a preceding SOP while idle (orphans) are swallowed and counted.
//
// Ports
//   clk, reset_n          CMAC TX AVST clock, async active-low reset
//   arb_en                allow new grants (an in-flight packet always completes)
//   in_valid/sop/eop/err  per-requester AVST control, one bit per requester
//   in_data, in_empty     packed per-requester payload, requester i at [i*W +: W]
//   in_ready              per-requester ready
//   out_*                 registered AVST beat to the CMAC, out_ready from CMAC
//   busy                  packet in flight (LOCK)
//   grant_idx             current or most recent grant
//   pkt_cnt               EOPs forwarded, wraps
//   drop_cnt              orphan beats discarded, saturates at 0xFFFF

// Per-requester ready/accept/orphan decode.
module eth_tx_avst_rr_arb_lane (
  input  logic locked,
  input  logic granted,
  input  logic out_free,
  input  logic valid,
  input  logic sop,
  output logic ready,
  output logic orphan,
  output logic accept
);
  assign orphan = ~locked & valid & ~sop;
  // While locked only the grant may move, and only if the output stage has room.
  // While idle only orphans are taken; SOP beats wait for the grant.
  assign ready  = locked ? (granted & out_free) : orphan;
  assign accept = locked & granted & valid & out_free;
endmodule

module eth_tx_avst_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 64,
  parameter int EMPTY_W = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       arb_en,
  input  logic [NUM_REQ-1:0]         in_valid,
  input  logic [NUM_REQ-1:0]         in_sop,
  input  logic [NUM_REQ-1:0]         in_eop,
  input  logic [NUM_REQ*DATA_W-1:0]  in_data,
  input  logic [NUM_REQ*EMPTY_W-1:0] in_empty,
  input  logic [NUM_REQ-1:0]         in_err,
  output logic [NUM_REQ-1:0]         in_ready,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic                       out_err,
  output logic [DATA_W-1:0]          out_data,
  output logic [EMPTY_W-1:0]         out_empty,
  input  logic                       out_ready,
  output logic                       busy,
  output logic [2:0]                 grant_idx,
  output logic [31:0]                pkt_cnt,
  output logic [15:0]                drop_cnt
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t state;
  logic [2:0] last_grant;
  logic       first_beat;   // next accepted beat is the packet's first

  logic               locked, out_free;
  logic [NUM_REQ-1:0] gnt_oh, orphan, accept, req;

  assign locked   = (state == LOCK);
  assign out_free = out_ready | ~out_valid;
  assign req      = in_valid & in_sop;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) gnt_oh[i] = (grant_idx == 3'(i));
  end

  eth_tx_avst_rr_arb_lane u_lane [NUM_REQ-1:0] (
    .locked   (locked),
    .granted  (gnt_oh),
    .out_free (out_free),
    .valid    (in_valid),
    .sop      (in_sop),
    .ready    (in_ready),
    .orphan   (orphan),
    .accept   (accept)
  );

  // Round-robin pick: distance 0 is last_grant+1, so the previous winner
  // ranks last. Lowest distance among SOP requesters wins.
  logic       hit;
  logic [2:0] win;
  int         best_d, d;
  always_comb begin
    best_d = NUM_REQ;
    d      = 0;
    win    = last_grant;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req[i]) begin
        d = (i + 2*NUM_REQ - 1 - int'(last_grant)) % NUM_REQ;
        if (d < best_d) begin
          best_d = d;
          win    = 3'(i);
        end
      end
    end
    hit = (best_d < NUM_REQ);
  end

  // Granted requester's beat fields.
  logic               sel_sop, sel_eop, sel_err;
  logic [DATA_W-1:0]  sel_data;
  logic [EMPTY_W-1:0] sel_empty;
  always_comb begin
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    sel_err   = 1'b0;
    sel_data  = '0;
    sel_empty = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_sop   = in_sop[i];
        sel_eop   = in_eop[i];
        sel_err   = in_err[i];
        sel_data  = in_data[i*DATA_W +: DATA_W];
        sel_empty = in_empty[i*EMPTY_W +: EMPTY_W];
      end
    end
  end

  logic acc;
  assign acc = |accept;

  // Orphan count for this cycle, added with saturation.
  logic [3:0]  n_orph;
  logic [16:0] drop_sum;
  always_comb begin
    n_orph = '0;
    for (int i = 0; i < NUM_REQ; i++) n_orph = n_orph + 4'(orphan[i]);
    drop_sum = {1'b0, drop_cnt} + 17'(n_orph);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 3'(NUM_REQ-1);
      grant_idx  <= '0;
      busy       <= 1'b0;
      first_beat <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_en && hit) begin
            state      <= LOCK;
            grant_idx  <= win;
            last_grant <= win;
            busy       <= 1'b1;
            first_beat <= 1'b1;
          end
        end
        LOCK: begin
          if (acc) begin
            first_beat <= 1'b0;
            if (sel_eop) begin
              state   <= IDLE;
              busy    <= 1'b0;
              pkt_cnt <= pkt_cnt + 32'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (drop_sum[16]) begin
      drop_cnt <= 16'hFFFF;
    end else begin
      drop_cnt <= drop_sum[15:0];
    end
  end

  // Output stage. A repeated SOP inside a packet is passed on but flagged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_err   <= 1'b0;
      out_data  <= '0;
      out_empty <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_sop   <= sel_sop;
      out_eop   <= sel_eop;
      out_err   <= sel_err | (sel_sop & ~first_beat);
      out_data  <= sel_data;
      out_empty <= sel_empty;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eth_tx_avst_rr_arb.sv
module tb_eth_tx_avst_rr_arb;
  localparam int N = 4;

  logic         clk = 0;
  logic         reset_n;
  logic         arb_en;
  logic [N-1:0] in_valid, in_sop, in_eop, in_err, in_ready;
  logic [N*64-1:0] in_data;
  logic [N*3-1:0]  in_empty;
  logic         out_valid, out_sop, out_eop, out_err, out_ready, busy;
  logic [63:0]  out_data;
  logic [2:0]   out_empty, grant_idx;
  logic [31:0]  pkt_cnt;
  logic [15:0]  drop_cnt;

  eth_tx_avst_rr_arb #(.NUM_REQ(N), .DATA_W(64), .EMPTY_W(3)) dut (
    .clk(clk), .reset_n(reset_n), .arb_en(arb_en),
    .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_data(in_data),
    .in_empty(in_empty), .in_err(in_err), .in_ready(in_ready),
    .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err),
    .out_data(out_data), .out_empty(out_empty), .out_ready(out_ready),
    .busy(busy), .grant_idx(grant_idx), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sop, eop, err;
    logic [2:0]  empty;
    logic [63:0] data;
  } beat_t;

  // Source model: per-requester beat memory, presented in order.
  beat_t mem [N][16];
  int    rd [N];
  int    wr [N];
  bit    flood;
  beat_t rx [$];
  int    total = 0;
  int    bad = 0;

  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (flood) begin
        in_valid[r] = 1'b1; in_sop[r] = 1'b0; in_eop[r] = 1'b0; in_err[r] = 1'b0;
        in_data[r*64 +: 64] = '0; in_empty[r*3 +: 3] = '0;
      end else if (rd[r] < wr[r]) begin
        in_valid[r] = 1'b1;
        in_sop[r] = mem[r][rd[r]].sop;
        in_eop[r] = mem[r][rd[r]].eop;
        in_err[r] = mem[r][rd[r]].err;
        in_data[r*64 +: 64] = mem[r][rd[r]].data;
        in_empty[r*3 +: 3] = mem[r][rd[r]].empty;
      end else begin
        in_valid[r] = 1'b0; in_sop[r] = 1'b0; in_eop[r] = 1'b0; in_err[r] = 1'b0;
        in_data[r*64 +: 64] = '0; in_empty[r*3 +: 3] = '0;
      end
    end
  endtask

  task automatic clear_src();
    for (int r = 0; r < N; r++) begin rd[r] = 0; wr[r] = 0; end
    flood = 0;
  endtask

  task automatic push_beat(int r, bit s, bit e, logic [63:0] d, logic [2:0] em);
    beat_t b;
    b.sop = s; b.eop = e; b.err = 1'b0; b.empty = em; b.data = d;
    mem[r][wr[r]] = b;
    wr[r]++;
  endtask

  // n-beat packet, data base+b; beat 'dup' (if >0) carries a spurious SOP.
  task automatic push_pkt(int r, int n, logic [63:0] base, int dup);
    for (int b = 0; b < n; b++)
      push_beat(r, (b == 0) || (b == dup), b == n-1, base + 64'(b), (b == n-1) ? 3'd2 : 3'd0);
  endtask

  // One clock: sample handshakes on the falling edge, advance sources after the rising edge.
  task automatic tick();
    logic [N-1:0] acc;
    beat_t o;
    @(negedge clk);
    acc = in_valid & in_ready;
    if (out_valid && out_ready) begin
      o.sop = out_sop; o.eop = out_eop; o.err = out_err; o.empty = out_empty; o.data = out_data;
      rx.push_back(o);
    end
    @(posedge clk); #1;
    for (int r = 0; r < N; r++)
      if (acc[r] && !flood && rd[r] < wr[r]) rd[r]++;
    drive();
  endtask

  task automatic do_reset();
    reset_n = 0; out_ready = 1; arb_en = 1;
    clear_src(); drive();
    @(posedge clk); #1;
    reset_n = 1;
    rx.delete();
  endtask

  task automatic test_reset();
    reset_n = 1; out_ready = 1; arb_en = 1; clear_src(); drive();
    #3 reset_n = 0; #1;
    total++; if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_err !== 1'b0)
      begin bad++; $display("FAIL reset_ctl got v%b s%b e%b r%b exp 0", out_valid, out_sop, out_eop, out_err); end
    total++; if (out_data !== 64'd0 || out_empty !== 3'd0)
      begin bad++; $display("FAIL reset_data got %h/%h exp 0", out_data, out_empty); end
    total++; if (busy !== 1'b0 || grant_idx !== 3'd0)
      begin bad++; $display("FAIL reset_busy_grant got %b/%0d exp 0/0", busy, grant_idx); end
    total++; if (pkt_cnt !== 32'd0 || drop_cnt !== 16'd0)
      begin bad++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", pkt_cnt, drop_cnt); end
    total++; if (in_ready !== 4'b0000)
      begin bad++; $display("FAIL reset_ready got %b exp 0000", in_ready); end
    @(posedge clk); #1; reset_n = 1;
  endtask

  task automatic test_single();
    do_reset();
    push_beat(0, 1, 0, 64'h11, 3'd0);
    push_beat(0, 0, 0, 64'h22, 3'd0);
    push_beat(0, 0, 1, 64'h33, 3'd2);
    drive(); #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL single_arb_ready got %b exp 0000", in_ready); end
    tick(); #1;
    total++; if (busy !== 1'b1 || grant_idx !== 3'd0 || out_valid !== 1'b0)
      begin bad++; $display("FAIL single_grant got busy%b g%0d v%b exp 1/0/0", busy, grant_idx, out_valid); end
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL single_lock_ready got %b exp 0001", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== 64'h11)
      begin bad++; $display("FAIL single_b0 got v%b s%b %h exp 1/1/11", out_valid, out_sop, out_data); end
    tick();
    total++; if (out_sop !== 1'b0 || out_data !== 64'h22)
      begin bad++; $display("FAIL single_b1 got s%b %h exp 0/22", out_sop, out_data); end
    tick();
    total++; if (out_eop !== 1'b1 || out_empty !== 3'd2 || out_data !== 64'h33)
      begin bad++; $display("FAIL single_b2 got e%b em%0d %h exp 1/2/33", out_eop, out_empty, out_data); end
    total++; if (busy !== 1'b0 || pkt_cnt !== 32'd1)
      begin bad++; $display("FAIL single_done got busy%b pkt%0d exp 0/1", busy, pkt_cnt); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_round_robin();
    logic [63:0] e;
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < N; r++) push_pkt(r, 2, 64'(r*256 + p*16), 0);
    drive();
    for (int c = 0; c < 23; c++) tick();
    total++; if (pkt_cnt !== 32'd7) begin bad++; $display("FAIL rr_cnt23 got %0d exp 7", pkt_cnt); end
    tick();
    total++; if (pkt_cnt !== 32'd8) begin bad++; $display("FAIL rr_cnt24 got %0d exp 8", pkt_cnt); end
    tick();
    total++; if (rx.size() !== 16) begin bad++; $display("FAIL rr_beats got %0d exp 16", rx.size()); end
    for (int k = 0; k < 8; k++)
      for (int b = 0; b < 2; b++)
        if (k*2+b < rx.size()) begin
          e = 64'((k%4)*256 + (k/4)*16 + b);
          total++; if (rx[k*2+b].data !== e || rx[k*2+b].sop !== (b == 0) || rx[k*2+b].eop !== (b == 1))
            begin bad++; $display("FAIL rr_beat%0d got %h s%b e%b exp %h", k*2+b, rx[k*2+b].data, rx[k*2+b].sop, rx[k*2+b].eop, e); end
        end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_pkt(2, 4, 64'hA0, 0);
    drive();
    tick(); tick();
    total++; if (out_valid !== 1'b1 || out_data !== 64'hA0)
      begin bad++; $display("FAIL bp_first got v%b %h exp 1/a0", out_valid, out_data); end
    out_ready = 0; #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready_drop got %b exp 0000", in_ready); end
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_sop !== 1'b1 || out_data !== 64'hA0 || in_ready !== 4'b0000)
        begin bad++; $display("FAIL bp_hold%0d got v%b s%b %h rdy%b exp 1/1/a0/0000", c, out_valid, out_sop, out_data, in_ready); end
    end
    out_ready = 1; #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL bp_ready_back got %b exp 0100", in_ready); end
    for (int c = 0; c < 5; c++) tick();
    total++; if (rx.size() !== 4) begin bad++; $display("FAIL bp_beats got %0d exp 4", rx.size()); end
    for (int b = 0; b < 4; b++)
      if (b < rx.size()) begin
        total++; if (rx[b].data !== 64'hA0 + 64'(b))
          begin bad++; $display("FAIL bp_beat%0d got %h exp %h", b, rx[b].data, 64'hA0 + 64'(b)); end
      end
    total++; if (pkt_cnt !== 32'd1) begin bad++; $display("FAIL bp_cnt got %0d exp 1", pkt_cnt); end
  endtask

  task automatic test_orphans();
    do_reset();
    for (int b = 0; b < 3; b++) begin
      push_beat(1, 0, 0, 64'h100 + 64'(b), 3'd0);
      push_beat(2, 0, 0, 64'h200 + 64'(b), 3'd0);
    end
    drive(); #1;
    total++; if (in_ready !== 4'b0110) begin bad++; $display("FAIL orph_ready got %b exp 0110", in_ready); end
    tick();
    total++; if (drop_cnt !== 16'd2) begin bad++; $display("FAIL orph_cnt1 got %0d exp 2", drop_cnt); end
    tick(); tick();
    total++; if (drop_cnt !== 16'd6) begin bad++; $display("FAIL orph_cnt3 got %0d exp 6", drop_cnt); end
    tick(); tick();
    total++; if (drop_cnt !== 16'd6 || rx.size() !== 0 || busy !== 1'b0)
      begin bad++; $display("FAIL orph_quiet got drop%0d rx%0d busy%b exp 6/0/0", drop_cnt, rx.size(), busy); end
  endtask

  task automatic test_arb_en();
    logic [63:0] exp_d [8];
    exp_d = '{64'h500, 64'h501, 64'h502, 64'h503, 64'h520, 64'h521, 64'h510, 64'h511};
    do_reset();
    push_pkt(0, 4, 64'h500, 0);
    push_pkt(0, 2, 64'h510, 0);
    push_pkt(1, 2, 64'h520, 0);
    drive();
    tick(); tick();
    arb_en = 0;
    tick(); tick(); tick();
    total++; if (busy !== 1'b0 || pkt_cnt !== 32'd1 || out_eop !== 1'b1)
      begin bad++; $display("FAIL en_complete got busy%b pkt%0d eop%b exp 0/1/1", busy, pkt_cnt, out_eop); end
    tick(); tick(); tick(); #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 4'b0000)
      begin bad++; $display("FAIL en_hold got busy%b v%b rdy%b exp 0/0/0000", busy, out_valid, in_ready); end
    arb_en = 1;
    tick();
    total++; if (busy !== 1'b1 || grant_idx !== 3'd1)
      begin bad++; $display("FAIL en_resume got busy%b g%0d exp 1/1", busy, grant_idx); end
    for (int c = 0; c < 7; c++) tick();
    total++; if (pkt_cnt !== 32'd3 || rx.size() !== 8)
      begin bad++; $display("FAIL en_total got pkt%0d rx%0d exp 3/8", pkt_cnt, rx.size()); end
    for (int b = 0; b < 8; b++)
      if (b < rx.size()) begin
        total++; if (rx[b].data !== exp_d[b])
          begin bad++; $display("FAIL en_beat%0d got %h exp %h", b, rx[b].data, exp_d[b]); end
      end
  endtask

  task automatic test_reset_dup_sop();
    logic [63:0] exp_d [5];
    logic [4:0]  exp_sop, exp_err;
    exp_d = '{64'h700, 64'h701, 64'h730, 64'h731, 64'h732};
    exp_sop = 5'b01101;   // bit b = beat b
    exp_err = 5'b01000;
    do_reset();
    push_pkt(3, 4, 64'h600, 0);
    drive();
    tick(); tick(); tick();
    total++; if (out_valid !== 1'b1 || busy !== 1'b1 || grant_idx !== 3'd3)
      begin bad++; $display("FAIL rst_mid_pre got v%b busy%b g%0d exp 1/1/3", out_valid, busy, grant_idx); end
    reset_n = 0; clear_src(); drive(); #1;
    total++; if (out_valid !== 1'b0 || out_eop !== 1'b0 || busy !== 1'b0 || grant_idx !== 3'd0 || in_ready !== 4'b0000)
      begin bad++; $display("FAIL rst_mid_squash got v%b e%b busy%b g%0d rdy%b exp 0/0/0/0/0000", out_valid, out_eop, busy, grant_idx, in_ready); end
    @(posedge clk); #1;
    reset_n = 1; rx.delete();
    push_pkt(3, 3, 64'h730, 1);
    push_pkt(0, 2, 64'h700, 0);
    drive();
    tick();
    total++; if (grant_idx !== 3'd0) begin bad++; $display("FAIL rst_prio got %0d exp 0", grant_idx); end
    for (int c = 0; c < 8; c++) tick();
    total++; if (rx.size() !== 5) begin bad++; $display("FAIL dup_beats got %0d exp 5", rx.size()); end
    for (int b = 0; b < 5; b++)
      if (b < rx.size()) begin
        total++; if (rx[b].data !== exp_d[b] || rx[b].sop !== exp_sop[b] || rx[b].err !== exp_err[b])
          begin bad++; $display("FAIL dup_beat%0d got %h s%b r%b exp %h s%b r%b", b, rx[b].data, rx[b].sop, rx[b].err, exp_d[b], exp_sop[b], exp_err[b]); end
      end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    arb_en = 0;
    flood = 1; drive();
    for (int c = 0; c < 16383; c++) tick();
    total++; if (drop_cnt !== 16'd65532 || out_valid !== 1'b0)
      begin bad++; $display("FAIL sat_near got %0d v%b exp 65532/0", drop_cnt, out_valid); end
    tick();
    total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hit got %h exp ffff", drop_cnt); end
    tick(); tick();
    total++; if (drop_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_stick got %h exp ffff", drop_cnt); end
    flood = 0; drive();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_orphans();
    test_arb_en();
    test_reset_dup_sop();
    test_drop_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eth_tx_avst_rr_arb.md
# eth_tx_avst_rr_arb

- Packet-atomic round-robin arbiter that shares the single 100G E-tile CMAC TX AVST port among NUM_REQ AVST packet sources, such as HSSI traffic-generator lanes and loopback paths.
- Sits between the AXIS→AVST bridges and the CMAC TX AVST port, in the CMAC TX clock domain.
- Locks the grant from SOP to EOP and drives the CMAC through one registered output stage.
- Provides enable/drain control and status counters for CSR readback.

## Interface
Parameters:
- NUM_REQ, 4 — number of requesters (2..8).
- DATA_W, 64 — AVST data width.
- EMPTY_W, 3 — empty field width.

Ports:
- clk  in  1  CMAC TX AVST clock (eth_tx_cmac_avl_clk domain); the block's only clock.
- reset_n  in  1  asynchronous active-low reset.
- arb_en  in  1  grants new packets when 1; when 0, the current packet completes and no new grant is issued.
- in_valid  in  NUM_REQ  per-requester beat valid.
- in_sop  in  NUM_REQ  per-requester start of packet.
- in_eop  in  NUM_REQ  per-requester end of packet.
- in_data  in  NUM_REQ*DATA_W  packed data; requester i occupies [i*DATA_W +: DATA_W].
- in_empty  in  NUM_REQ*EMPTY_W  packed empty field.
- in_err  in  NUM_REQ  per-requester error flag.
- in_ready  out  NUM_REQ  per-requester ready.
- out_valid, out_sop, out_eop, out_err  out  1 each  registered AVST beat to the CMAC.
- out_data  out  DATA_W  registered beat data.
- out_empty  out  EMPTY_W  registered beat empty field.
- out_ready  in  1  CMAC tx ready.
- busy  out  1  1 while in LOCK state.
- grant_idx  out  3  current or most recent grant index.
- pkt_cnt  out  32  packets forwarded (EOPs accepted); wraps.
- drop_cnt  out  16  orphan beats discarded; saturates at 0xFFFF.

## Operation
- States: IDLE and LOCK.
- IDLE:
  - When arb_en=1, scan requesters in order last_grant+1, +2, … (mod NUM_REQ) for in_valid&in_sop. The first hit becomes the grant.
  - Register grant_idx and last_grant, then go to LOCK next cycle. No beat is accepted in the arbitration cycle.
- Orphan beats:
  - An orphan is any requester in IDLE presenting in_valid=1 with in_sop=0.
  - Orphans are accepted (in_ready=1) and discarded, and drop_cnt increments once per beat.
  - If several orphans occur in the same cycle, drop_cnt increments by their count.
  - Orphan handling is independent of arb_en.
- LOCK, ready rule:
  - Only the granted requester sees in_ready = out_ready | ~out_valid. All other requesters have in_ready=0.
- LOCK, beat transfer:
  - An accepted beat (valid&ready) is copied into the output register.
  - In the same cycle, if the granted requester asserts in_sop on a non-first beat, the beat is forwarded unchanged with out_err forced to 1.
- LOCK, end of packet:
  - An accepted beat with in_eop=1 increments pkt_cnt and returns the FSM to IDLE.
  - A single-beat packet (sop&eop) is legal.
- arb_en has no effect in LOCK. Deasserting it mid-packet does not truncate the packet.
- Output register:
  - Loads on any accepted beat.
  - Clears out_valid when out_ready=1 and no new beat is accepted.
  - Holds all fields while out_valid=1 and out_ready=0.
- Fairness: after requester k's packet, requester k has the lowest priority at the next arbitration.

## Timing
- Reset values (async, immediate):
  - FSM=IDLE; last_grant=NUM_REQ-1, so requester 0 wins first.
  - grant_idx=0, busy=0.
  - out_valid=out_sop=out_eop=out_err=0; out_data=0, out_empty=0.
  - in_ready=0 except orphan acceptance in IDLE.
  - pkt_cnt=0, drop_cnt=0.
- Latency: in_valid&sop seen in IDLE at cycle N → grant registered at N+1 → first beat accepted at N+1 → out_valid at N+2.
- Inter-packet overhead: one idle cycle per arbitration.
- Back-to-back beats from the granted requester at full rate while out_ready=1.
- out_ready deasserted: in_ready of the grant drops in the same cycle (combinational) once out_valid=1. The output beat holds stable.
- Reset asserted mid-packet: the output is squashed immediately with no EOP generated. The downstream MAC sees the partial packet terminated by reset.
- Counters update on the clock edge that accepts the relevant beat.

## Test plan
- Single requester 0, 3-beat packet (data 0x11,0x22,0x33, eop empty=2), out_ready=1:
  - Output beats appear on cycles N+2..N+4 with sop on the first and eop+empty=2 on the last.
  - pkt_cnt=1, busy returns to 0.
- All 4 requesters continuously sending 2-beat packets:
  - Grant order is 0,1,2,3,0,1… with one bubble between packets.
  - Packets are never interleaved.
  - pkt_cnt=8 after 8 packets.
- Backpressure: out_ready toggling 1,0,0,1 mid-packet:
  - out_* is held stable while stalled and in_ready=0 during the stall.
  - No beat is lost or duplicated; data is checked in order.
- Orphans: requesters 1 and 2 present valid with no sop in IDLE for 3 cycles:
  - drop_cnt=6 and no output beats.
  - Saturation: preload near 0xFFFF → counter sticks at 0xFFFF.
- arb_en=0 asserted during beat 2 of a 4-beat packet:
  - The packet completes and the FSM stays in IDLE.
  - No new grant despite pending sop; arb_en=1 resumes with the next round-robin requester.
- Reset mid-packet, then a sop on requester 3 with a duplicate sop in the packet:
  - After reset, requester 0 has priority when both request.
  - A mid-packet duplicate sop gives out_err=1 on that beat.
